// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the multi-outstanding fetch queue.
//   OP_*        opcode fields recognised by predecode
//   NOP         word substituted for blank BRAM reads
//   BRAM_BLANK  erased/uninitialised BRAM word
//   fetch_tag_t {pc, epoch} carried alongside each outstanding BRAM read
//   fifo_entry_t one buffered instruction
package fetch_pkg;

    localparam logic [4:0]  OP_J       = 5'b00001;
    localparam logic [5:0]  OP_BC      = 6'b110010;
    localparam logic [4:0]  OP_BEQ_BNE = 5'b00010;

    localparam logic [31:0] NOP        = 32'h0;
    localparam logic [31:0] BRAM_BLANK = 32'hffffffff;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  epoch;
    } fetch_tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
    } fifo_entry_t;

endpackage

// File: rtl/fetch_predecode.sv
// fetch_predecode: combinational static predictor for a returning instruction word.
//   w_i       instruction word (already sanitised)
//   p_i       byte PC of that word
//   taken_o   word is a statically-taken control transfer
//   target_o  byte target when taken_o, else 0
// J/JAL and BC are always taken; BEQ/BNE only when the offset is negative (backward loop).
module fetch_predecode
    import fetch_pkg::*;
(
    input  logic [31:0] w_i,
    input  logic [31:0] p_i,
    output logic        taken_o,
    output logic [31:0] target_o
);

    always_comb begin
        taken_o  = 1'b0;
        target_o = 32'h0;
        if (w_i[31:27] == OP_J) begin
            taken_o  = 1'b1;
            target_o = {4'b0000, w_i[25:0], 2'b00};
        end else if (w_i[31:26] == OP_BC) begin
            taken_o  = 1'b1;
            target_o = p_i + {4'b0000, w_i[25:0], 2'b00};
        end else if ((w_i[31:27] == OP_BEQ_BNE) && w_i[15]) begin
            // w[15] set means the sign-extended offset is negative
            taken_o  = 1'b1;
            target_o = p_i + {14'h3fff, w_i[15:0], 2'b00};
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: keeps up to DEPTH instruction reads outstanding/buffered against a
// fixed-latency instruction BRAM and presents them to decode one per cycle.
//   clk, rstn                 clock, synchronous active-low reset
//   redirect_valid/_pc        execute-stage redirect; flushes FIFO, bumps epoch
//   out_valid/_ready          decode handshake on the FIFO head
//   out_pc/_inst/_pred_taken  head contents (0 while empty)
//   inst_enable/inst_addr     BRAM read strobe and word address
//   inst_data                 BRAM data, MEM_LAT cycles after the strobe
// Build option: define FETCH_PREDICT_EN to enable static predecode steering;
// without it fetch is strictly sequential apart from redirects.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_LAT  = 1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_inst,
    output logic              out_pred_taken,
    output logic              inst_enable,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic [31:0]       inst_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [1:0]       epoch_q, epoch_d;
    logic             pipe_valid_q [MEM_LAT];
    logic             pipe_valid_d [MEM_LAT];
    fetch_tag_t       pipe_tag_q   [MEM_LAT];
    fetch_tag_t       pipe_tag_d   [MEM_LAT];
    fifo_entry_t      fifo_q       [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       inflight;
    logic [CNT_W:0]   credit_used;
    logic             ret_valid;
    fetch_tag_t       ret_tag;
    logic [31:0]      ret_word;
    logic             ret_accept;
    logic             pd_taken;
    logic [31:0]      pd_target;
    logic             pred_redirect;
    logic             issue;
    logic             do_enq;
    logic             do_deq;
    fifo_entry_t      fifo_wdata;
    fifo_entry_t      head;

    // Return side: the oldest tag lines up with inst_data this cycle.
    assign ret_valid  = pipe_valid_q[MEM_LAT-1];
    assign ret_tag    = pipe_tag_q[MEM_LAT-1];
    assign ret_word   = (inst_data == BRAM_BLANK) ? NOP : inst_data;
    // Reads issued before the latest redirect carry a stale epoch and are dropped.
    assign ret_accept = ret_valid && (ret_tag.epoch == epoch_q);

`ifdef FETCH_PREDICT_EN
    fetch_predecode u_predecode (
        .w_i      (ret_word),
        .p_i      (ret_tag.pc),
        .taken_o  (pd_taken),
        .target_o (pd_target)
    );
`else
    assign pd_taken  = 1'b0;
    assign pd_target = 32'h0;
`endif

    always_comb begin
        inflight = 2'd0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + {1'b0, pipe_valid_q[i]};
        end
    end

    // Credits cover both buffered entries and reads still in the BRAM pipe,
    // so a return always finds a free slot.
    assign credit_used   = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight);
    assign pred_redirect = ret_accept && pd_taken && !redirect_valid;
    assign issue         = rstn && !redirect_valid && !pred_redirect && (credit_used < DEPTH_C);
    assign do_enq        = ret_accept && !redirect_valid;
    assign do_deq        = out_valid && out_ready && !redirect_valid;
    assign fifo_wdata    = '{pc: ret_tag.pc, inst: ret_word, pred_taken: pd_taken};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            epoch_d    = epoch_q + 2'd1;
        end else if (pred_redirect) begin
            fetch_pc_d = pd_target;
            epoch_d    = epoch_q + 2'd1;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        pipe_valid_d[0] = issue;
        pipe_tag_d[0]   = '{pc: fetch_pc_q, epoch: epoch_q};
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_tag_d[i]   = pipe_tag_q[i-1];
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_enq) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 2'd0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_tag_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            epoch_q      <= epoch_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
        end
    end

    // Storage needs no reset: it is only visible through count_q.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            fifo_q[wr_ptr_q] <= fifo_wdata;
        end
    end

    assign head           = fifo_q[rd_ptr_q];
    assign out_valid      = (count_q != '0);
    assign out_pc         = out_valid ? head.pc : 32'h0;
    assign out_inst       = out_valid ? head.inst : 32'h0;
    assign out_pred_taken = out_valid && head.pred_taken;
    assign inst_enable    = issue;
    assign inst_addr      = fetch_pc_q[ADDR_W+1:2];

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a one-cycle BRAM model.
// Cycle k of a run is the clock period in which rstn is first seen high at k=0;
// inputs are driven at the falling edge and outputs sampled 1ns later.
module tb_fetch_queue;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MEM_LAT = 1;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_pc;
    logic [31:0]       out_inst;
    logic              out_pred_taken;
    logic              inst_enable;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data = 32'h0;

    logic [31:0] mem [256];
    logic [31:0] got_pc [32];
    logic        got_pt [32];
    logic [31:0] got_inst [32];
    logic        en_hist [32];
    int          n_got;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pred_taken (out_pred_taken),
        .inst_enable    (inst_enable),
        .inst_addr      (inst_addr),
        .inst_data      (inst_data)
    );

    always #5 clk = ~clk;

    // Registered BRAM read, latency 1.
    always @(posedge clk) begin
        if (inst_enable) inst_data <= mem[inst_addr[7:0]];
    end

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0100 + i;
    endtask

    // Leaves rstn low with at least two reset edges seen.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Runs a fresh stream from reset with out_ready=1, recording deliveries.
    task automatic run_collect(input int cycles);
        n_got = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b1;
            redirect_valid = 1'b0;
            #1;
            en_hist[c] = inst_enable;
            if (out_valid && n_got < 32) begin
                got_pc[n_got]   = out_pc;
                got_pt[n_got]   = out_pred_taken;
                got_inst[n_got] = out_inst;
                n_got++;
            end
        end
    endtask

    task automatic test_reset();
        fill_mem();
        do_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b expected 0", out_valid); miscompares++;
        end
        vectors++;
        if (inst_enable !== 1'b0) begin
            $display("FAIL reset_inst_enable: got %b expected 0", inst_enable); miscompares++;
        end
        vectors++;
        if ({out_pc, out_inst, out_pred_taken} !== 65'h0) begin
            $display("FAIL reset_outputs: got pc=%h inst=%h pt=%b expected zeros",
                     out_pc, out_inst, out_pred_taken);
            miscompares++;
        end
    endtask

    task automatic test_sequential();
        fill_mem();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b1;
            #1;
            vectors++;
            if (inst_enable !== 1'b1 || inst_addr !== ADDR_W'(k)) begin
                $display("FAIL seq_issue cycle %0d: got en=%b addr=%h expected en=1 addr=%h",
                         k, inst_enable, inst_addr, k);
                miscompares++;
            end
            vectors++;
            if (k < 2) begin
                if (out_valid !== 1'b0) begin
                    $display("FAIL seq_early_valid cycle %0d: got %b expected 0", k, out_valid);
                    miscompares++;
                end
            end else if (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 2)) ||
                         out_inst !== 32'h100 + 32'(k - 2)) begin
                $display("FAIL seq_out cycle %0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                         k, out_valid, out_pc, out_inst, 4 * (k - 2), 32'h100 + 32'(k - 2));
                miscompares++;
            end
        end
    endtask

    task automatic test_stall();
        int issued;
        logic [31:0] exp_pc;
        issued = 0;
        fill_mem();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b0;
            #1;
            if (inst_enable) issued++;
            if (k >= 4) begin
                vectors++;
                if (inst_enable !== 1'b0) begin
                    $display("FAIL stall_no_issue cycle %0d: got %b expected 0", k, inst_enable);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (issued != DEPTH) begin
            $display("FAIL stall_issue_count: got %0d expected %0d", issued, DEPTH);
            miscompares++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc);
            miscompares++;
        end
        exp_pc = 32'h0;
        for (int k = 10; k < 20; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
                $display("FAIL stall_release cycle %0d: got v=%b pc=%h expected v=1 pc=%h",
                         k, out_valid, out_pc, exp_pc);
                miscompares++;
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

`ifdef FETCH_PREDICT_EN
    task automatic test_predict_jump();
        logic [31:0] exp_pc [5];
        logic        exp_pt [5];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
        exp_pt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        fill_mem();
        mem[2] = 32'h0800_0010;  // J to 0x40 at PC 0x8
        do_reset();
        run_collect(10);
        vectors++;
        if (n_got != 7) begin
            $display("FAIL jump_count: got %0d expected 7", n_got); miscompares++;
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (got_pc[i] !== exp_pc[i] || got_pt[i] !== exp_pt[i]) begin
                $display("FAIL jump_seq[%0d]: got pc=%h pt=%b expected pc=%h pt=%b",
                         i, got_pc[i], got_pt[i], exp_pc[i], exp_pt[i]);
                miscompares++;
            end
        end
        vectors++;
        if (en_hist[3] !== 1'b0) begin
            $display("FAIL jump_issue_hold: got %b expected 0", en_hist[3]); miscompares++;
        end
    endtask

    task automatic test_predict_branch();
        // Backward BEQ at 0x20, offset -1 word: target 0x20 - 4 = 0x1C
        fill_mem();
        mem[8] = 32'h1000_FFFF;
        do_reset();
        run_collect(16);
        vectors++;
        if (n_got != 12) begin
            $display("FAIL beq_back_count: got %0d expected 12", n_got); miscompares++;
        end
        vectors++;
        if (got_pc[8] !== 32'h20 || got_pt[8] !== 1'b1) begin
            $display("FAIL beq_back_branch: got pc=%h pt=%b expected pc=00000020 pt=1",
                     got_pc[8], got_pt[8]);
            miscompares++;
        end
        vectors++;
        if (got_pc[9] !== 32'h1C || got_pt[9] !== 1'b0 || got_pc[10] !== 32'h20) begin
            $display("FAIL beq_back_target: got %h,%h pt=%b expected 0000001c,00000020 pt=0",
                     got_pc[9], got_pc[10], got_pt[9]);
            miscompares++;
        end
        // Forward BEQ: not predicted
        fill_mem();
        mem[8] = 32'h1000_0002;
        do_reset();
        run_collect(14);
        vectors++;
        if (got_pc[8] !== 32'h20 || got_pt[8] !== 1'b0 || got_pc[9] !== 32'h24) begin
            $display("FAIL beq_fwd: got pc=%h pt=%b next=%h expected 00000020 pt=0 next=00000024",
                     got_pc[8], got_pt[8], got_pc[9]);
            miscompares++;
        end
    endtask
`else
    task automatic test_no_predict();
        fill_mem();
        mem[2] = 32'h0800_0010;
        do_reset();
        run_collect(8);
        vectors++;
        if (got_pc[2] !== 32'h8 || got_pt[2] !== 1'b0 || got_pc[3] !== 32'hC) begin
            $display("FAIL nopred_jump: got pc=%h pt=%b next=%h expected 00000008 pt=0 next=0000000c",
                     got_pc[2], got_pt[2], got_pc[3]);
            miscompares++;
        end
    endtask
`endif

    task automatic test_redirect();
        fill_mem();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b0;
        end
        // Cycle 6: FIFO full, decode ready, redirect to 0x100
        @(negedge clk);
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        vectors++;
        if (inst_enable !== 1'b0 || out_valid !== 1'b1) begin
            $display("FAIL redir_cycle: got en=%b v=%b expected en=0 v=1", inst_enable, out_valid);
            miscompares++;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || inst_enable !== 1'b1 || inst_addr !== ADDR_W'(16'h40)) begin
            $display("FAIL redir_t1: got v=%b en=%b addr=%h expected v=0 en=1 addr=0040",
                     out_valid, inst_enable, inst_addr);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            $display("FAIL redir_t2: got v=%b expected 0", out_valid); miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            $display("FAIL redir_t3: got v=%b pc=%h expected v=1 pc=00000100", out_valid, out_pc);
            miscompares++;
        end
        @(negedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
            $display("FAIL redir_t4: got v=%b pc=%h expected v=1 pc=00000104", out_valid, out_pc);
            miscompares++;
        end
    endtask

    task automatic test_sanitise_and_reset();
        fill_mem();
        mem[1] = 32'hffff_ffff;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            out_ready = 1'b1;
            #1;
            if (k == 3) begin
                vectors++;
                if (out_pc !== 32'h4 || out_inst !== 32'h0) begin
                    $display("FAIL blank_to_nop: got pc=%h inst=%h expected pc=00000004 inst=00000000",
                             out_pc, out_inst);
                    miscompares++;
                end
            end
        end
        // Cycle 6: reset pulse mid-stream
        @(negedge clk);
        rstn = 1'b0;
        #1;
        vectors++;
        if (inst_enable !== 1'b0) begin
            $display("FAIL midreset_enable: got %b expected 0", inst_enable); miscompares++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rstn = 1'b1;
            #1;
            vectors++;
            if (k == 0 && (out_valid !== 1'b0 || inst_enable !== 1'b1 || inst_addr !== '0)) begin
                $display("FAIL midreset_restart: got v=%b en=%b addr=%h expected v=0 en=1 addr=0000",
                         out_valid, inst_enable, inst_addr);
                miscompares++;
            end else if (k == 1 && out_valid !== 1'b0) begin
                $display("FAIL midreset_empty: got v=%b expected 0", out_valid);
                miscompares++;
            end else if (k >= 2 && (out_valid !== 1'b1 || out_pc !== 32'(4 * (k - 2)))) begin
                $display("FAIL midreset_stream k=%0d: got v=%b pc=%h expected v=1 pc=%h",
                         k, out_valid, out_pc, 4 * (k - 2));
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
`ifdef FETCH_PREDICT_EN
        test_predict_jump();
        test_predict_branch();
`else
        test_no_predict();
`endif
        test_redirect();
        test_sanitise_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
